// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell processes a WIDTH-bit
// operation LSB first, one bit per clock, with a start/busy/done handshake.

module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opa_q, opb_q, res_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q, cout_q, ovf_q;
  logic             fa_s, fa_co;

  fullAdder u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtract is a + ~b + 1: invert B and seed the carry with 1.
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          carry_q <= fa_co;
          res_q   <= {fa_s, res_q[WIDTH-1:1]};
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // carry_q is the carry into the MSB on this final bit
            sum_q   <= {fa_s, res_q[WIDTH-1:1]};
            cout_q  <= fa_co;
            ovf_q   <= carry_q ^ fa_co;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench: WIDTH=8 directed + random ops and exhaustive WIDTH=4,
// compared every cycle against a transaction-level arithmetic model.

module tb_serial_add_ctrl;
  logic clk = 1'b0, rst_n = 1'b1;

  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       busy8, done8, cout8, ovf8;

  logic       start4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       busy4, done4, cout4, ovf4;

  int total = 0, bad = 0;
  int dones4 = 0, accepts4 = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {overflow, cout, sum[7:0]} for a w-bit operation.
  function automatic logic [9:0] alu(input int unsigned w, input logic [7:0] x,
                                     input logic [7:0] y, input logic s);
    int unsigned mask, ux, uy, t;
    int sx, sy, r;
    logic [9:0] o;
    mask = (32'd1 << w) - 1;
    ux = 32'(x) & mask;
    uy = 32'(y) & mask;
    t  = ux + (s ? (~uy & mask) : uy) + 32'(s);
    sx = (ux >= (32'd1 << (w - 1))) ? int'(ux) - int'(32'd1 << w) : int'(ux);
    sy = (uy >= (32'd1 << (w - 1))) ? int'(uy) - int'(32'd1 << w) : int'(uy);
    r  = s ? sx - sy : sx + sy;
    o = '0;
    o[7:0] = 8'(t & mask);
    o[8]   = t[w];
    o[9]   = (r < -int'(32'd1 << (w - 1))) || (r >= int'(32'd1 << (w - 1)));
    return o;
  endfunction

  // Transaction model: an accepted op yields its result w cycles later.
  int         m_rem  [2];
  logic       m_busy [2], m_done [2], m_cout [2], m_ovf [2];
  logic [7:0] m_sum  [2];
  logic [9:0] m_pend [2];

  initial for (int k = 0; k < 2; k++) begin
    m_rem[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_cout[k] = 0; m_ovf[k] = 0;
    m_sum[k] = '0; m_pend[k] = '0;
  end

  always @(posedge clk or negedge rst_n) begin
    logic st, sv;
    logic [7:0] av, bv;
    int unsigned w;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_rem[k] <= 0; m_busy[k] <= 0; m_done[k] <= 0;
        m_sum[k] <= '0; m_cout[k] <= 0; m_ovf[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        st = (k == 1) ? start4 : start8;
        sv = (k == 1) ? sub4 : sub8;
        av = (k == 1) ? {4'b0, a4} : a8;
        bv = (k == 1) ? {4'b0, b4} : b8;
        w  = (k == 1) ? 4 : 8;
        m_done[k] <= 1'b0;
        if (m_rem[k] == 0) begin
          if (st) begin
            m_pend[k] <= alu(w, av, bv, sv);
            m_rem[k]  <= int'(w);
            m_busy[k] <= 1'b1;
            if (k == 1) accepts4 <= accepts4 + 1;
          end
        end else begin
          m_rem[k] <= m_rem[k] - 1;
          if (m_rem[k] == 1) begin
            m_done[k] <= 1'b1;
            m_busy[k] <= 1'b0;
            m_sum[k]  <= m_pend[k][7:0];
            m_cout[k] <= m_pend[k][8];
            m_ovf[k]  <= m_pend[k][9];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy8", busy8, m_busy[0]);
      check("done8", done8, m_done[0]);
      check("sum8",  sum8,  m_sum[0]);
      check("cout8", cout8, m_cout[0]);
      check("ovf8",  ovf8,  m_ovf[0]);
      check("busy4", busy4, m_busy[1]);
      check("done4", done4, m_done[1]);
      check("sum4",  sum4,  m_sum[1][3:0]);
      check("cout4", cout4, m_cout[1]);
      check("ovf4",  ovf4,  m_ovf[1]);
      if (done4 === 1'b1) dones4++;
    end
  end

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic s,
                      input logic [7:0] es, input logic ec, input logic eo,
                      input string nm, input bit glitch);
    int n;
    @(posedge clk); #1;
    a8 = x; b8 = y; sub8 = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (glitch && n == 3) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
      end
      if (glitch && n == 4) start8 = 1'b0;
    end
    start8 = 1'b0;
    check({nm, " latency"}, n, 8);
    check({nm, " sum"}, sum8, es);
    check({nm, " cout"}, cout8, ec);
    check({nm, " ovf"}, ovf8, eo);
  endtask

  task automatic exhaustive4();
    logic [9:0] e;
    int n;
    for (int unsigned x = 0; x < 16; x++)
      for (int unsigned y = 0; y < 16; y++)
        for (int unsigned s = 0; s < 2; s++) begin
          @(posedge clk); #1;
          a4 = 4'(x); b4 = 4'(y); sub4 = 1'(s); start4 = 1'b1;
          @(posedge clk); #1;
          start4 = 1'b0;
          n = 0;
          while (done4 !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
          end
          e = alu(4, {4'b0, 4'(x)}, {4'b0, 4'(y)}, 1'(s));
          check("x4 latency", n, 4);
          check("x4 result", {ovf4, cout4, sum4}, {e[9], e[8], e[3:0]});
        end
  endtask

  task automatic random8();
    repeat (3000) begin
      @(posedge clk); #1;
      start8 = ($urandom_range(0, 2) == 0);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      sub8 = 1'($urandom);
    end
    start8 = 1'b0;
  endtask

  initial begin
    int n, c;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    check("rst busy", busy8, 0);
    check("rst done", done8, 0);
    check("rst sum", sum8, 0);
    check("rst cout", cout8, 0);
    check("rst ovf", ovf8, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "add 35+4A", 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add FF+01", 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add 7F+01", 1'b0);
    run8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub 10-20", 1'b0);
    run8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub 80-01", 1'b0);
    run8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "ignore start", 1'b1);

    // start held through DONE: second op accepted in the DONE cycle
    @(posedge clk); #1;
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h9C; b8 = 8'h27; sub8 = 1'b1;
    n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b first latency", n, 8);
    check("b2b first sum", sum8, 8'h46);
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
      start8 = 1'b0;
    end while (done8 !== 1'b1 && c < 20);
    check("b2b done spacing", c, 9);
    check("b2b second sum", sum8, 8'h75);
    check("b2b second cout", cout8, 1);
    check("b2b second ovf", ovf8, 1);

    // reset in the middle of an add
    @(posedge clk); #1;
    a8 = 8'h35; b8 = 8'h4A; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", busy8, 0);
    check("midrst done", done8, 0);
    check("midrst sum", sum8, 0);
    check("midrst cout", cout8, 0);
    check("midrst ovf", ovf8, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "post-reset 01+01", 1'b0);

    fork
      exhaustive4();
      random8();
    join
    repeat (12) @(posedge clk);
    #1;
    check("done4 vs accepts", dones4, accepts4);
    check("done4 count", dones4, 512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
